// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling FSM, one-entry
// valid/ready holding register with frame-error pulse and sticky overrun.
module uart_rx #(
    parameter int CLK_FREQ_HZ  = 27_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    input  logic       READY,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [1:0]    r_sync;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_done;
    logic          r_ferr;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ovr;
    logic          w_rx_s;
    logic          w_tick;

    assign w_rx_s = r_sync[1];
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], RXD};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            if (!w_tick) r_cnt <= r_cnt - CW'(1);
            case (r_state)
                S_IDLE: if (!w_rx_s) begin
                    r_state <= S_START;
                    r_cnt   <= HALF;
                end
                S_START: if (w_tick) begin
                    if (!w_rx_s) begin
                        r_state <= S_DATA;
                        r_cnt   <= FULL;
                        r_idx   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: if (w_tick) begin
                    r_shift <= {w_rx_s, r_shift[7:1]};
                    r_cnt   <= FULL;
                    r_idx   <= r_idx + 3'd1;
                    if (r_idx == 3'd7) r_state <= S_STOP;
                end
                S_STOP: if (w_tick) begin
                    if (w_rx_s) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_ferr  <= 1'b1;
                        r_state <= S_BREAK;
                    end
                end
                S_BREAK: if (w_rx_s) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A delivery into a full register that is being read the same cycle is
    // not an overrun; a drop beats a simultaneous accept for OVERRUN.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (r_done) begin
            if (!r_valid || READY) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid) r_ovr <= 1'b0;
            end else begin
                r_ovr <= 1'b1;
            end
        end else if (r_valid && READY) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign DATA      = r_data;
    assign VALID     = r_valid;
    assign FRAME_ERR = r_ferr;
    assign OVERRUN   = r_ovr;
    assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at 4 clocks per bit, checked
// against a frame-level model of the holding register.
module tb_uart_rx;
    localparam int CPB = 4;
    localparam int DLY = 4 + CPB / 2 - CPB;  // negedges from end of stop bit to VALID

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RXD = 1'b1;
    logic       READY = 1'b0;
    logic [7:0] DATA;
    logic       VALID, FRAME_ERR, OVERRUN, BUSY;

    uart_rx #(.CLK_FREQ_HZ(16), .BAUD_RATE(4)) dut (
        .CLK(CLK), .RESET(RESET), .RXD(RXD), .READY(READY),
        .DATA(DATA), .VALID(VALID), .FRAME_ERR(FRAME_ERR),
        .OVERRUN(OVERRUN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;

    always @(negedge CLK) if (FRAME_ERR === 1'b1) fe_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_deliver(input logic [7:0] b, input logic rdy);
        if (!m_valid || rdy) begin
            if (m_valid) m_ovr = 1'b0;
            m_data  = b;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic m_accept();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 8'h00;
    endtask

    // Must be entered at a negedge; returns at the negedge ending the stop bit.
    task automatic send(input logic [7:0] b, input logic stopb);
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RXD = stopb;
        repeat (CPB) @(negedge CLK);
        RXD = 1'b1;
    endtask

    task automatic frame_ok(input string tag, input logic [7:0] b);
        int f0;
        f0 = fe_cnt;
        send(b, 1'b1);
        repeat (DLY) @(negedge CLK);
        m_deliver(b, 1'b0);
        chk({tag, "_ferr"}, fe_cnt - f0, 0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic accept();
        READY = 1'b1;
        @(negedge CLK);
        READY = 1'b0;
        m_accept();
    endtask

    task automatic cmp_state(input string tag);
        chk({tag, "_valid"}, VALID, m_valid);
        chk({tag, "_data"}, DATA, m_data);
        chk({tag, "_ovr"}, OVERRUN, m_ovr);
        chk({tag, "_busy"}, BUSY, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        logic saw;
        logic [7:0] b;
        #2 RESET = 1'b0;
        repeat (2) @(negedge CLK);
        cmp_state("reset");
        chk("reset_ferr", FRAME_ERR, 0);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);

        // 1: single byte, latency, accept
        send(8'hA5, 1'b1);
        repeat (DLY - 1) @(negedge CLK);
        chk("t1_early_valid", VALID, 0);
        @(negedge CLK);
        m_deliver(8'hA5, 1'b0);
        chk("t1_valid", VALID, 1);
        chk("t1_data", DATA, 8'hA5);
        chk("t1_ferr", fe_cnt, 0);
        repeat (2) @(negedge CLK);
        cmp_state("t1_held");
        accept();
        cmp_state("t1_acc");

        // 2: one-cycle glitch
        f0 = fe_cnt;
        saw = 1'b0;
        RXD = 1'b0;
        @(negedge CLK);
        RXD = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (BUSY) saw = 1'b1;
        end
        chk("t2_saw_busy", saw, 1);
        chk("t2_ferr", fe_cnt - f0, 0);
        cmp_state("t2");

        // 3: line stuck low from reset release
        RESET = 1'b0;
        RXD = 1'b0;
        m_reset();
        repeat (2) @(negedge CLK);
        f0 = fe_cnt;
        RESET = 1'b1;
        repeat (100) @(negedge CLK);
        chk("t3_one_ferr", fe_cnt - f0, 1);
        chk("t3_valid", VALID, 0);
        chk("t3_busy_break", BUSY, 1);
        RXD = 1'b1;
        repeat (4) @(negedge CLK);
        chk("t3_idle", BUSY, 0);
        frame_ok("t3", 8'h3C);
        cmp_state("t3");
        accept();

        // 4: overrun
        frame_ok("t4a", 8'h11);
        frame_ok("t4b", 8'h22);
        cmp_state("t4");
        chk("t4_ovr_set", OVERRUN, 1);
        accept();
        cmp_state("t4_acc");

        // 5: accept coinciding with the next delivery
        frame_ok("t5a", 8'h55);
        send(8'h66, 1'b1);
        repeat (DLY - 1) @(negedge CLK);
        READY = 1'b1;
        @(negedge CLK);
        READY = 1'b0;
        m_deliver(8'h66, 1'b1);
        repeat (2) @(negedge CLK);
        cmp_state("t5");
        chk("t5_data", DATA, 8'h66);

        // 6: reset mid-frame during bit 4 of 0xFF
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            RXD = 1'b1;
            repeat (CPB) @(negedge CLK);
        end
        chk("t6_busy_pre", BUSY, 1);
        RESET = 1'b0;
        #1;
        m_reset();
        cmp_state("t6_rst");
        @(negedge CLK);
        RESET = 1'b1;
        repeat (4) @(negedge CLK);
        frame_ok("t6", 8'h81);
        cmp_state("t6");
        accept();

        // randomized frames: good, bad stop, optional accepts
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                f0 = fe_cnt;
                send(b, 1'b0);
                repeat (6) @(negedge CLK);
                chk("rnd_badstop_ferr", fe_cnt - f0, 1);
            end else begin
                frame_ok("rnd", b);
            end
            cmp_state("rnd");
            if ($urandom_range(0, 1) == 1) begin
                accept();
                cmp_state("rnd_acc");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
